bin2bcd_seq: RTL and testbench

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

---
 rtl/bin2bcd_seq.sv | 86 ++++++++
 tb/tb_bin2bcd_seq.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary to 4-digit BCD converter.
// Saturates inputs above MAXVAL and flags them through ovf.
module bin2bcd_seq #(
  parameter int MAXVAL = 9999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] bin,
  output logic        busy,
  output logic        done,
  output logic [15:0] number,
  output logic        ovf
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [15:0] MAXV = 16'(MAXVAL);

  state_t      state;
  logic [15:0] acc;
  logic [13:0] opd;
  logic [3:0]  cnt;
  logic        ovf_next;
  logic [15:0] adj;
  logic        over;

  assign over = (bin > MAXV);

  // add-3 correction so each nibble stays decimal after the shift
  always_comb begin
    adj = acc;
    for (int i = 0; i < 4; i++) begin
      if (acc[i*4 +: 4] >= 4'd5)
        adj[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      acc      <= '0;
      opd      <= '0;
      cnt      <= '0;
      ovf_next <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      number   <= '0;
      ovf      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            opd      <= over ? MAXV[13:0]
                             : bin[13:0];
            acc      <= '0;
            cnt      <= '0;
            ovf_next <= over;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          busy       <= 1'b1;
          {acc, opd} <= {adj[14:0], opd, 1'b0};
          cnt        <= cnt + 4'd1;
          if (cnt == 4'd13)
            state <= DONE;
        end
        DONE: begin
          busy   <= 1'b0;
          number <= acc;
          ovf    <= ovf_next;
          done   <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq.
// Covers latency, saturation, start masking, back-to-back and reset abort.
module tb_bin2bcd_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] bin;
  logic        busy;
  logic        done;
  logic [15:0] number;
  logic        ovf;

  int total;
  int bad;

  bin2bcd_seq #(.MAXVAL(9999)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .bin    (bin),
    .busy   (busy),
    .done   (done),
    .number (number),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h",
               tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] tobcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10),
            4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  // start on the next edge, then follow the handshake to done
  task automatic convert(
    input string       tag,
    input logic [15:0] v,
    input logic [15:0] en,
    input logic        eo
  );
    int k;
    int nb;
    k  = 0;
    nb = 0;
    bin   = v;
    start = 1'b1;
    cyc();
    start = 1'b0;
    bin   = 16'($urandom);
    while (k < 20) begin
      cyc();
      k++;
      if (busy) nb++;
      if (done) break;
    end
    chk({tag, ".lat"}, k, 15);
    chk({tag, ".busy"}, nb, 14);
    chk({tag, ".bsyd"}, busy, 0);
    chk({tag, ".num"}, number, en);
    chk({tag, ".ovf"}, ovf, eo);
  endtask

  initial begin
    int nd;
    int k;
    logic [15:0] hold;
    total = 0;
    bad   = 0;
    reset = 1'b0;
    start = 1'b0;
    bin   = '0;
    #1;
    chk("rst", {busy, done, ovf, number}, 0);
    cyc();
    cyc();
    reset = 1'b1;
    cyc();

    convert("c1234", 16'd1234, 16'h1234, 1'b0);
    convert("c0", 16'd0, 16'h0000, 1'b0);
    convert("c9999", 16'd9999, 16'h9999, 1'b0);
    convert("c10000", 16'd10000, 16'h9999, 1'b1);
    convert("cffff", 16'hFFFF, 16'h9999, 1'b1);

    // outputs hold while idle and bin wanders
    hold = number;
    repeat (6) begin
      bin = 16'($urandom);
      cyc();
    end
    chk("hold.num", number, hold);
    chk("hold.ovf", ovf, 1);
    chk("hold.done", done, 0);

    // reset in the middle of a conversion
    bin   = 16'd8765;
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (7) cyc();
    reset = 1'b0;
    #1;
    chk("abort.out", {busy, done, ovf, number}, 0);
    nd = 0;
    repeat (3) begin
      cyc();
      if (done) nd++;
    end
    reset = 1'b1;
    repeat (20) begin
      cyc();
      if (done) nd++;
    end
    chk("abort.nodone", nd, 0);
    chk("abort.num", number, 0);
    convert("c8765", 16'd8765, 16'h8765, 1'b0);

    // start during SHIFT must be ignored
    cyc();
    bin   = 16'd4321;
    start = 1'b1;
    cyc();
    start = 1'b0;
    nd = 0;
    k  = 0;
    for (int i = 1; i <= 40; i++) begin
      if (i == 5) begin
        bin   = 16'd5555;
        start = 1'b1;
      end
      cyc();
      start = 1'b0;
      if (done) begin
        nd++;
        if (k == 0) k = i;
      end
    end
    chk("ign.count", nd, 1);
    chk("ign.lat", k, 15);
    chk("ign.num", number, 16'h4321);

    // back-to-back: second start lands in the done cycle
    convert("b2b7", 16'd7, 16'h0007, 1'b0);
    chk("b2b.done", done, 1);
    convert("b2b42", 16'd42, 16'h0042, 1'b0);

    for (int v = 0; v <= 9999; v += 97)
      convert("sweep", 16'(v), tobcd(v), 1'b0);
    convert("s5000", 16'd5000, 16'h5000, 1'b0);
    convert("s9998", 16'd9998, 16'h9998, 1'b0);
    convert("s909", 16'd909, 16'h0909, 1'b0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
